cfg_word_loader: RTL
====================

Name: cfg_word_loader

Overview:
- Parametrised successor to the tile's word-wide configuration latch bank. It loads NUM_WORDS configuration words over a valid/ready stream into a shadow register bank.
- When the load completes, the whole shadow bank is committed atomically to the active configuration outputs, so the fabric never sees a partially written configuration.
- Supports two load modes: sequential auto-increment and random-addressed.
- Provides a sticky done flag, a sticky range-error flag and a registered readback port. Sits between the tile configuration bus and the LUT/switch-box config inputs.

Parameters:
- WORD_W, 32: width of one configuration word.
- NUM_WORDS, 31: number of configuration words (>=2).
- ADDR_W, 5: word-address width; must satisfy 2**ADDR_W >= NUM_WORDS.
- CFG_W: derived as WORD_W*NUM_WORDS; local, not overridable.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- io_start  in  1  begin or restart a load session.
- io_mode  in  1  0 = sequential auto-increment, 1 = random-addressed; sampled on the io_start cycle.
- io_d_in  in  WORD_W  config word.
- io_d_addr  in  ADDR_W  target word index; used in random mode only.
- io_d_valid  in  1  word valid.
- io_d_ready  out  1  word accepted when io_d_valid & io_d_ready.
- io_commit  in  1  end a random-mode session; ignored in sequential mode.
- io_configs_out  out  CFG_W  active config; word k occupies bits [k*WORD_W +: WORD_W].
- io_done  out  1  sticky; set on commit, cleared by io_start.
- io_err  out  1  sticky; out-of-range address seen this session.
- io_rd_addr  in  ADDR_W  readback index into the active bank.
- io_rd_data  out  WORD_W  registered readback data.

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE, shadow=0, io_configs_out=0, ptr=0, mode register=0.
  - io_done=0, io_err=0, io_rd_data=0.
- FSM states: IDLE, LOAD, COMMIT.
- IDLE:
  - io_d_ready=0.
  - io_start -> LOAD; ptr<=0; mode latched from io_mode; io_done<=0; io_err<=0.
- LOAD:
  - io_d_ready = ~io_start (combinational).
  - Accept = io_d_valid & io_d_ready.
  - Sequential mode:
    - Accept writes shadow[ptr] and sets ptr<=ptr+1.
    - Accept at ptr==NUM_WORDS-1 -> COMMIT; ptr does not wrap.
  - Random mode:
    - Accept with io_d_addr<NUM_WORDS writes shadow[io_d_addr].
    - Accept with io_d_addr>=NUM_WORDS drops the word and sets io_err<=1.
    - io_commit -> COMMIT.
    - io_commit together with an accept: the word is written first, so it is included in the commit.
  - io_start in LOAD restarts the session: ptr<=0, mode re-latched, flags cleared, shadow contents retained, no data accepted that cycle.
- COMMIT (exactly one cycle):
  - io_d_ready=0.
  - io_configs_out<=shadow in a single edge; io_done<=1; -> IDLE.
  - io_start during COMMIT is ignored; it must be re-asserted in IDLE.
- Latency: the last sequential word accepted at edge N appears on io_configs_out and io_done after edge N+1.
- Invariant: io_configs_out changes only on the COMMIT edge or on reset; it never reflects partial loads.
- Readback: io_rd_data<=active[io_rd_addr] every cycle (1-cycle latency); an index >=NUM_WORDS returns 0.
- Un-written shadow words keep their prior values; a random-mode commit of partial data is legal.
- Reset asserted mid-LOAD aborts the session and clears both banks.
- Flag lifetime: io_err and io_done persist through IDLE until the next io_start.

Decomposition:
- Shared package cfg_pkg: state enum (IDLE/LOAD/COMMIT), MODE_SEQ/MODE_RAND constants, and a function to compute the address width from a word count.
- One natural sub-module, cfg_bank: NUM_WORDS x WORD_W register array with write-enable/address, a bulk copy-in port and an indexed read.
  - Instantiated twice: once as shadow, once as active.
- FSM, pointer and flags live in the top level.

Test Plan:
- Reset, then start in sequential mode and stream 31 words 0x1000+k with valid held high -> ready high for 31 cycles; io_configs_out stays 0 until the cycle after the last accept; then word k = 0x1000+k and io_done=1.
- Random mode: write addr 3=0xDEADBEEF, addr 30=0x12345678, then io_commit -> only those words change; io_done=1 after 1 cycle; io_err=0.
- Random mode with io_d_addr=31 and data 0xFFFFFFFF -> word dropped, io_err=1, active unchanged after commit.
- io_start asserted on word 10 of a sequential load -> ready=0 that cycle; next accepted word lands at index 0; io_done clears.
- Reset driven low mid-LOAD after 5 words -> all outputs 0 immediately (asynchronous); the next start loads cleanly.
- Readback: after a load, set io_rd_addr=7 -> io_rd_data=0x1007 one cycle later; io_rd_addr=31 -> io_rd_data=0.

Source files
------------

// File: rtl/cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cfg_pkg
// Description : Shared types and helpers for the configuration word loader.
// Revision    : 1.0 - initial release
// ============================================================================
package cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    localparam logic MODE_SEQ  = 1'b0;
    localparam logic MODE_RAND = 1'b1;

    // Minimum word-address width able to index a bank of the given size.
    function automatic int addr_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cfg_bank.sv
`default_nettype none
// ============================================================================
// Module      : cfg_bank
// Description : NUM_WORDS x WORD_W register bank with single-word write,
//               whole-bank copy-in and an indexed combinational read.
// Revision    : 1.0 - initial release
// ============================================================================
module cfg_bank #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 31,
    parameter int ADDR_W    = 5,
    localparam int CFG_W    = WORD_W * NUM_WORDS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WORD_W-1:0] i_wr_data,
    input  logic              i_load_en,
    input  logic [CFG_W-1:0]  i_load_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WORD_W-1:0] o_rd_data,
    output logic [CFG_W-1:0]  o_words
);

    for (genvar k = 0; k < NUM_WORDS; k++) begin : g_word
        logic [WORD_W-1:0] r_word;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_word <= '0;
            end else if (i_load_en) begin
                r_word <= i_load_data[k*WORD_W +: WORD_W];
            end else if (i_wr_en && (i_wr_addr == ADDR_W'(k))) begin
                r_word <= i_wr_data;
            end
        end

        assign o_words[k*WORD_W +: WORD_W] = r_word;
    end

    // Indices past the last word match nothing and read as zero.
    always_comb begin
        o_rd_data = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            if (i_rd_addr == ADDR_W'(k)) begin
                o_rd_data = o_words[k*WORD_W +: WORD_W];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cfg_word_loader.sv
`default_nettype none
// ============================================================================
// Module      : cfg_word_loader
// Description : Streams configuration words into a shadow bank and commits
//               the whole bank atomically to the active configuration.
// Revision    : 1.0 - initial release
// ============================================================================
module cfg_word_loader
    import cfg_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 31,
    parameter int ADDR_W    = 5,
    localparam int CFG_W    = WORD_W * NUM_WORDS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              io_start,
    input  logic              io_mode,
    input  logic [WORD_W-1:0] io_d_in,
    input  logic [ADDR_W-1:0] io_d_addr,
    input  logic              io_d_valid,
    output logic              io_d_ready,
    input  logic              io_commit,
    output logic [CFG_W-1:0]  io_configs_out,
    output logic              io_done,
    output logic              io_err,
    input  logic [ADDR_W-1:0] io_rd_addr,
    output logic [WORD_W-1:0] io_rd_data
);

    localparam int              C_MIN_ADDR_W = addr_width(NUM_WORDS);
    localparam logic [ADDR_W:0] C_NUM_WORDS  = (ADDR_W + 1)'(NUM_WORDS);
    localparam logic [ADDR_W-1:0] C_LAST_PTR = ADDR_W'(NUM_WORDS - 1);

    if (ADDR_W < C_MIN_ADDR_W) begin : g_addr_w_check
        $error("cfg_word_loader: ADDR_W too small for NUM_WORDS");
    end

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W-1:0]   r_ptr;
    logic                r_mode;
    logic                r_done;
    logic                r_err;
    logic [WORD_W-1:0]   r_rd_data;

    logic                w_ready;
    logic                w_accept;
    logic                w_restart;
    logic                w_in_range;
    logic                w_wr_en;
    logic [ADDR_W-1:0]   w_wr_addr;
    logic                w_commit;
    logic [CFG_W-1:0]    w_shadow_words;
    logic [WORD_W-1:0]   w_active_rd;
    logic [WORD_W-1:0]   w_shadow_rd_unused;

    assign w_in_range = ({1'b0, io_d_addr} < C_NUM_WORDS);

    always_comb begin
        w_next_state = r_state;
        w_ready      = 1'b0;
        w_accept     = 1'b0;
        w_restart    = 1'b0;
        w_wr_en      = 1'b0;
        w_wr_addr    = r_ptr;
        w_commit     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (io_start) begin
                    w_restart    = 1'b1;
                    w_next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_ready  = ~io_start;
                w_accept = io_d_valid & w_ready;
                if (io_start) begin
                    w_restart = 1'b1;
                end else if (r_mode == MODE_SEQ) begin
                    if (w_accept) begin
                        w_wr_en = 1'b1;
                        if (r_ptr == C_LAST_PTR) begin
                            w_next_state = ST_COMMIT;
                        end
                    end
                end else begin
                    // A word accepted alongside io_commit still lands before the copy.
                    if (w_accept && w_in_range) begin
                        w_wr_en   = 1'b1;
                        w_wr_addr = io_d_addr;
                    end
                    if (io_commit) begin
                        w_next_state = ST_COMMIT;
                    end
                end
            end
            ST_COMMIT: begin
                w_commit     = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_mode    <= MODE_SEQ;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_state   <= w_next_state;
            r_rd_data <= w_active_rd;
            if (w_restart) begin
                r_ptr  <= '0;
                r_mode <= io_mode;
                r_done <= 1'b0;
                r_err  <= 1'b0;
            end else begin
                if (w_accept && (r_mode == MODE_SEQ)) begin
                    r_ptr <= r_ptr + 1'b1;
                end
                if (w_accept && (r_mode == MODE_RAND) && !w_in_range) begin
                    r_err <= 1'b1;
                end
                if (w_commit) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    cfg_bank #(
        .WORD_W    (WORD_W),
        .NUM_WORDS (NUM_WORDS),
        .ADDR_W    (ADDR_W)
    ) u_shadow (
        .clk         (clk),
        .reset       (reset),
        .i_wr_en     (w_wr_en),
        .i_wr_addr   (w_wr_addr),
        .i_wr_data   (io_d_in),
        .i_load_en   (1'b0),
        .i_load_data ('0),
        .i_rd_addr   ('0),
        .o_rd_data   (w_shadow_rd_unused),
        .o_words     (w_shadow_words)
    );

    cfg_bank #(
        .WORD_W    (WORD_W),
        .NUM_WORDS (NUM_WORDS),
        .ADDR_W    (ADDR_W)
    ) u_active (
        .clk         (clk),
        .reset       (reset),
        .i_wr_en     (1'b0),
        .i_wr_addr   ('0),
        .i_wr_data   ('0),
        .i_load_en   (w_commit),
        .i_load_data (w_shadow_words),
        .i_rd_addr   (io_rd_addr),
        .o_rd_data   (w_active_rd),
        .o_words     (io_configs_out)
    );

    assign io_d_ready = w_ready;
    assign io_done    = r_done;
    assign io_err     = r_err;
    assign io_rd_data = r_rd_data;

endmodule
`default_nettype wire
